// File: rtl/rv_core_pkg.sv
// Shared core definitions: arbiter state encoding and base data widths.
package rv_core_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_BUSY_I = 2'b01,
    ARB_BUSY_D = 2'b10
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: shares one memory port between instruction
// fetch and load/store. Data normally wins because it belongs to the older
// instruction. Each grant is held until mem_ack, then the FSM passes through
// one IDLE cycle before the next grant.
// Optional macro ARB_FAIR_EN: after STARVE_MAX consecutive data grants taken
// while fetch was waiting, fetch wins the next contested arbitration.
module mem_port_arbiter
  import rv_core_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  // instruction fetch side
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  // load/store side
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_done,
  // external memory
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  // hazard unit
  output logic                stall_f,
  output logic                stall_m
);

  localparam int PBE_W = DATA_W / 8;

  arb_state_e         state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [PBE_W-1:0]   mem_be_q, mem_be_d;

  logic fetch_first;  // fairness override: fetch beats data this arbitration
  logic take_d;       // data granted this cycle
  logic take_i;       // fetch granted this cycle

`ifdef ARB_FAIR_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_q, starve_d;

  assign fetch_first = (starve_q == CNT_W'(STARVE_MAX));

  // Starvation count: data grants taken over a waiting fetch; cleared by a fetch grant
  always_comb begin
    starve_d = starve_q;
    if (take_i) begin
      starve_d = '0;
    end else if (take_d && if_req && (starve_q != CNT_W'(STARVE_MAX))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign fetch_first = 1'b0;
`endif

  assign take_d = (state_q == ARB_IDLE) && dm_req && !(if_req && fetch_first);
  assign take_i = (state_q == ARB_IDLE) && if_req && !take_d;

  // Next state and next memory-request registers; bus is latched only on a grant
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    case (state_q)
      ARB_IDLE: begin
        if (take_d) begin
          state_d     = ARB_BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_be_d    = dm_be;
        end else if (take_i) begin
          state_d     = ARB_BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (mem_ack) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered memory-side outputs; reset abandons any transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

  // Completion is combinational on mem_ack so the pipeline can advance that cycle
  assign if_done  = (state_q == ARB_BUSY_I) && mem_ack;
  assign dm_done  = (state_q == ARB_BUSY_D) && mem_ack;
  assign if_rdata = mem_rdata;
  assign dm_rdata = mem_rdata;

  assign stall_f = if_req && !if_done;
  assign stall_m = dm_req && !dm_done;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single unified memory port between instruction fetch (IF stage) and load/store (MEM stage).
- Grants one requester at a time and holds the transaction until the memory acknowledges it.
- Generates the stall signals that the hazard logic uses to freeze the pipeline.
- Sits between the pipelined datapath and the external memory interface, driven by the decoded `mem_write_d`/`res_src_d` path after it reaches MEM.

Parameters:
- ADDR_W, 32, width of all address buses
- DATA_W, 32, width of the data buses; byte-enable width is DATA_W/8
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction; valid only when if_done=1
- if_done  out  1  fetch complete, one-cycle pulse
- dm_req  in  1  load/store request; held until dm_done
- dm_we  in  1  1 = store
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_be  in  DATA_W/8  byte enables
- dm_rdata  out  DATA_W  load data; valid only when dm_done=1
- dm_done  out  1  data access complete, one-cycle pulse
- mem_req  out  1  request to memory; held until mem_ack
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack
- mem_ack  in  1  memory completion, one-cycle pulse
- stall_f  out  1  freeze the fetch stage
- stall_m  out  1  freeze MEM and all older stages

Behaviour:
- FSM has three states: IDLE, BUSY_I, BUSY_D.
- Reset state:
  - state = IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata and mem_be = 0.
  - Starve counter = 0.
  - if_done and dm_done = 0.
- IDLE:
  - dm_req=1 → latch dm_* into the mem_* registers, mem_we=dm_we, go to BUSY_D.
  - Otherwise if_req=1 → latch if_addr, mem_we=0, mem_be=all ones, wdata=0, go to BUSY_I.
  - Both requests low → stay in IDLE.
  - Default priority is data over fetch, because the data access belongs to the older instruction.
- mem_req is registered. It is 1 in BUSY_I/BUSY_D and 0 in IDLE.
- mem_addr, mem_wdata, mem_be and mem_we hold stable for the whole BUSY state.
- BUSY_x:
  - Wait for mem_ack.
  - On mem_ack, x_done=1 combinationally in the same cycle, x_rdata=mem_rdata as a passthrough, next state = IDLE.
  - Wait states are unbounded.
- Latency:
  - Request sampled in IDLE at cycle N → mem_req=1 at N+1.
  - With zero-wait memory (mem_ack at N+1), done at N+1.
  - Minimum 2 cycles per transaction; back-to-back grants always pass through one IDLE cycle.
- Done outputs: if_done = (state==BUSY_I)&mem_ack; dm_done = (state==BUSY_D)&mem_ack. Otherwise both are 0 and the rdata outputs are don't-care.
- Stall outputs: stall_f = if_req & ~if_done; stall_m = dm_req & ~dm_done. Both are combinational.
- mem_ack while in IDLE: ignored, no done pulse.
- Requester deasserts req mid-transaction: the transaction still completes and the done pulse still fires; the requester discards it.
- A requester whose done fired re-arbitrates normally in the following IDLE cycle. Pipeline advance guarantees a new address by then.
- Reset asserted mid-transaction: FSM aborts immediately (asynchronously), mem_req drops, no done pulse. The memory must tolerate an abandoned request.
- Address and data are passed through unmodified. Misalignment checking is done elsewhere.

Optional Feature:
- Macro: ARB_FAIR_EN.
- When defined, a counter of width $clog2(STARVE_MAX+1) tracks starvation:
  - Increments on each BUSY_D grant taken while if_req=1.
  - Clears on any BUSY_I grant.
  - When the counter equals STARVE_MAX and both requests are high in IDLE, fetch wins and the counter clears.
- When not defined: strict data priority, no counter, STARVE_MAX unused.

Decomposition:
- Shared package rv_core_pkg:
  - state enumeration ARB_IDLE=2'b00, ARB_BUSY_I=2'b01, ARB_BUSY_D=2'b10.
  - XLEN=32 and BE_W=XLEN/8.
- Single module; no sub-module is warranted. The fairness counter is a few lines under the ifdef.

Test Plan:
- Fetch only, zero-wait: if_req=1, if_addr=0x0000_0010, mem_ack tied to mem_req with mem_rdata=0x0050_0093 → mem_req at N+1, mem_addr=0x10, mem_we=0, if_done at N+1, if_rdata=0x0050_0093, stall_f high only at cycle N.
- Simultaneous requests: if_req=1 (0x14), dm_req=1 store (0x100, wdata 0xDEAD_BEEF, be 4'b1111), 2 wait states → store granted first; mem_req held 3 cycles; dm_done; IDLE cycle; then fetch 0x14 granted.
- Load with byte enables: dm_addr=0x203, dm_be=4'b1000, dm_we=0, mem_rdata=0xAB00_0000 after 5 waits → mem_be=4'b1000, dm_rdata=0xAB00_0000, stall_m high for 6 cycles.
- Reset mid-transaction: grant BUSY_D, assert reset before mem_ack → mem_req=0 immediately, no dm_done; after release, the still-pending dm_req is re-granted.
- Spurious mem_ack in IDLE → no done pulse, state stays IDLE.
- ARB_FAIR_EN with STARVE_MAX=4: dm_req and if_req held high continuously → 4 data grants, then 1 fetch grant, repeating. Without the macro → fetch is never granted.
